// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// regfile_sb_pkg : shared widths and writeback bundle field offsets
// Revision 1.0
// ============================================================================
package regfile_sb_pkg;
  localparam int XLEN      = 64;
  localparam int RA_W      = 5;
  localparam int WB2RF_WD  = 1 + RA_W + XLEN;
  // Writeback packs {we, waddr, wdata}; both ends slice with these offsets.
  localparam int WDATA_LSB = 0;
  localparam int WADDR_LSB = WDATA_LSB + XLEN;
  localparam int WE_BIT    = WADDR_LSB + RA_W;
endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// regfile_sb_if : writeback, decode, scoreboard and debug signals of regfile_sb
// Revision 1.0
// ============================================================================
interface regfile_sb_if;
  import regfile_sb_pkg::*;

  logic [WB2RF_WD-1:0] wb2rf_bus;
  logic [RA_W-1:0]     rs1_addr;
  logic [RA_W-1:0]     rs2_addr;
  logic [XLEN-1:0]     rs1_data;
  logic [XLEN-1:0]     rs2_data;
  logic                issue_valid;
  logic                issue_we;
  logic [RA_W-1:0]     issue_rd;
  logic                flush;
  logic                rs1_busy;
  logic                rs2_busy;
  logic                sb_err;
  logic [RA_W-1:0]     dbg_raddr;
  logic [XLEN-1:0]     dbg_rdata;

  modport master (
    output wb2rf_bus, rs1_addr, rs2_addr, issue_valid, issue_we, issue_rd,
           flush, dbg_raddr,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, sb_err, dbg_rdata
  );

  modport slave (
    input  wb2rf_bus, rs1_addr, rs2_addr, issue_valid, issue_we, issue_rd,
           flush, dbg_raddr,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, sb_err, dbg_rdata
  );
endinterface
`default_nettype wire

// File: rtl/regfile_sb_counter.sv
`default_nettype none
// ============================================================================
// sb_counter : saturating pending-write counter with flush and error pulse
// Revision 1.0
// ============================================================================
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             inc,
  input  wire logic             dec,
  input  wire logic             flush,
  output logic [CNT_W-1:0]      cnt,
  output logic                  err
);
  localparam logic [CNT_W-1:0] c_max = '1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_up;
  logic             w_dn;

  assign w_up = inc & ~dec;
  assign w_dn = dec & ~inc;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_cnt <= '0;
    end else if (w_up && r_cnt != c_max) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (w_dn && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Flush wins, so an overflow/underflow in the flush cycle is not an error.
  assign err = ~flush & ((w_up & (r_cnt == c_max)) | (w_dn & (r_cnt == '0)));
  assign cnt = r_cnt;
endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// regfile_sb : integer register file with write bypass and pending-write scoreboard
// Revision 1.0
// ============================================================================
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  regfile_sb_if.slave bus
);
  logic             w_wb_we;
  logic [RA_W-1:0]  w_wb_addr;
  logic [XLEN-1:0]  w_wb_data;
  logic             w_wb_wr;
  logic             w_inc_any;
  logic [XLEN-1:0]  r_regs [1:31];
  logic [CNT_W-1:0] w_cnt [1:31];
  logic [31:1]      w_cnt_err;
  logic             r_sb_err;
  logic [XLEN-1:0]  r_dbg_rdata;

  assign w_wb_we   = bus.wb2rf_bus[WE_BIT];
  assign w_wb_addr = bus.wb2rf_bus[WADDR_LSB +: RA_W];
  assign w_wb_data = bus.wb2rf_bus[WDATA_LSB +: XLEN];
  assign w_wb_wr   = w_wb_we && (w_wb_addr != '0);
  assign w_inc_any = bus.issue_valid && bus.issue_we && (bus.issue_rd != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wb_wr) begin
      r_regs[w_wb_addr] <= w_wb_data;
    end
  end

  function automatic logic [XLEN-1:0] f_read(input logic [RA_W-1:0] a);
    if (a == '0)                       return '0;
    else if (w_wb_we && w_wb_addr == a) return w_wb_data;
    else                               return r_regs[a];
  endfunction

  // A sole outstanding writer retiring this cycle is covered by the bypass.
  function automatic logic f_busy(input logic [RA_W-1:0] a);
    if (a == '0) return 1'b0;
    return (w_cnt[a] != '0) &&
           !((w_cnt[a] == CNT_W'(1)) && w_wb_we && (w_wb_addr == a));
  endfunction

  for (genvar g = 1; g < 32; g++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_inc_any && (bus.issue_rd == RA_W'(g))),
      .dec   (w_wb_wr && (w_wb_addr == RA_W'(g))),
      .flush (bus.flush),
      .cnt   (w_cnt[g]),
      .err   (w_cnt_err[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sb_err    <= 1'b0;
      r_dbg_rdata <= '0;
    end else begin
      r_sb_err    <= r_sb_err | (|w_cnt_err);
      r_dbg_rdata <= f_read(bus.dbg_raddr);
    end
  end

  assign bus.rs1_data  = f_read(bus.rs1_addr);
  assign bus.rs2_data  = f_read(bus.rs2_addr);
  assign bus.rs1_busy  = f_busy(bus.rs1_addr);
  assign bus.rs2_busy  = f_busy(bus.rs2_addr);
  assign bus.sb_err    = r_sb_err;
  assign bus.dbg_rdata = r_dbg_rdata;
endmodule
`default_nettype wire
